// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// core_mem_arbiter_if
// Core memory request/response bundle; LANES packs several requestors.
// Revision: 1.0
// ============================================================================
interface core_mem_arbiter_if #(
  parameter int LANES  = 1,
  parameter int ADDR_W = 64,
  parameter int STRB_W = 8,
  parameter int DATA_W = 64
);
  logic [LANES-1:0]        req;
  logic [LANES*ADDR_W-1:0] addr;
  logic [LANES-1:0]        wen;
  logic [LANES*STRB_W-1:0] strb;
  logic [LANES*DATA_W-1:0] wdata;
  logic [LANES-1:0]        gnt;
  logic                    err;
  logic [DATA_W-1:0]       rdata;

  modport master (output req, addr, wen, strb, wdata, input  gnt, err, rdata);
  modport slave  (input  req, addr, wen, strb, wdata, output gnt, err, rdata);
endinterface
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// core_mem_arbiter
// Round-robin N-to-1 arbiter, one outstanding transaction, optional timeout.
// Revision: 1.0
// ============================================================================
module core_mem_arbiter #(
  parameter int  CHANNELS   = 2,
  parameter int  MEM_ADDR_W = 64,
  parameter int  MEM_STRB_W = 8,
  parameter int  MEM_DATA_W = 64,
  parameter int  TIMEOUT    = 255,
  localparam int OWNER_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  wire logic          g_clk,
  input  wire logic          g_resetn,
  core_mem_arbiter_if.slave  s,
  core_mem_arbiter_if.master m,
  output logic               busy,
  output logic [OWNER_W-1:0] owner,
  output logic               timeout
);
  localparam int c_IDX_W = OWNER_W + 1;
  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [OWNER_W-1:0] c_LAST_CH = OWNER_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [OWNER_W-1:0]      r_ptr, r_owner, w_winner, w_ptr_inc;
  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_found, w_done, w_timeout;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [MEM_ADDR_W-1:0]   r_addr;
  logic                    r_wen;
  logic [MEM_STRB_W-1:0]   r_strb;
  logic [MEM_DATA_W-1:0]   r_wdata;

  // Scan from the far end back to r_ptr so the nearest requester overwrites the rest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + c_IDX_W'(k);
      if (w_idx >= c_IDX_W'(CHANNELS)) w_idx = w_idx - c_IDX_W'(CHANNELS);
      if (s.req[w_idx[OWNER_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[OWNER_W-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_owner == c_LAST_CH) ? '0 : r_owner + OWNER_W'(1);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    s.gnt       = '0;
    s.err       = 1'b0;
    s.rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        s.err   = m.err;
        s.rdata = m.rdata;
        if (m.gnt[0]) begin
          s.gnt[r_owner] = 1'b1;
          w_done         = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
          s.gnt[r_owner] = 1'b1;
          s.err          = 1'b1;
          s.rdata        = '0;
          w_timeout      = 1'b1;
          w_state_nxt    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m.gnt[0]) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_strb  <= '0;
      r_wdata <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_owner <= w_winner;
        r_cnt   <= '0;
        r_addr  <= s.addr[w_winner*MEM_ADDR_W +: MEM_ADDR_W];
        r_wen   <= s.wen[w_winner];
        r_strb  <= s.strb[w_winner*MEM_STRB_W +: MEM_STRB_W];
        r_wdata <= s.wdata[w_winner*MEM_DATA_W +: MEM_DATA_W];
      end
      if (r_state == ST_BUSY) r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_done) r_ptr <= w_ptr_inc;
    end
  end

  assign m.req[0] = (r_state != ST_IDLE);
  assign m.addr   = r_addr;
  assign m.wen[0] = r_wen;
  assign m.strb   = r_strb;
  assign m.wdata  = r_wdata;
  assign busy     = (r_state != ST_IDLE);
  assign owner    = r_owner;
  assign timeout  = w_timeout;
endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_core_mem_arbiter
// Two arbiter instances (2ch no timeout, 4ch TIMEOUT=4) with directed and random traffic.
// Revision: 1.0
// ============================================================================
module tb_core_mem_arbiter;
  localparam int A0 = 64, S0 = 8, D0 = 64;
  localparam int A1 = 32, S1 = 4, D1 = 32;

  logic       g_clk = 1'b0;
  logic       rstn0, rstn1;
  logic       busy0, tmo0, busy1, tmo1;
  logic [0:0] own0;
  logic [1:0] own1;
  int         errors = 0;
  int         checks = 0;

  logic          pend [4];
  logic [A1-1:0] fa [4];
  logic          fw [4];
  logic [S1-1:0] fs [4];
  logic [D1-1:0] fd [4];

  always #5 g_clk = ~g_clk;

  core_mem_arbiter_if #(.LANES(2), .ADDR_W(A0), .STRB_W(S0), .DATA_W(D0)) s0 ();
  core_mem_arbiter_if #(.LANES(1), .ADDR_W(A0), .STRB_W(S0), .DATA_W(D0)) m0 ();
  core_mem_arbiter_if #(.LANES(4), .ADDR_W(A1), .STRB_W(S1), .DATA_W(D1)) s1 ();
  core_mem_arbiter_if #(.LANES(1), .ADDR_W(A1), .STRB_W(S1), .DATA_W(D1)) m1 ();

  core_mem_arbiter #(.CHANNELS(2), .MEM_ADDR_W(A0), .MEM_STRB_W(S0), .MEM_DATA_W(D0), .TIMEOUT(0)) dut0 (
    .g_clk(g_clk), .g_resetn(rstn0), .s(s0), .m(m0), .busy(busy0), .owner(own0), .timeout(tmo0));
  core_mem_arbiter #(.CHANNELS(4), .MEM_ADDR_W(A1), .MEM_STRB_W(S1), .MEM_DATA_W(D1), .TIMEOUT(4)) dut1 (
    .g_clk(g_clk), .g_resetn(rstn1), .s(s1), .m(m1), .busy(busy1), .owner(own1), .timeout(tmo1));

  task automatic nxt();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive1(input int c);
    s1.req[c]            = 1'b1;
    s1.addr[c*A1 +: A1]  = fa[c];
    s1.wen[c]            = fw[c];
    s1.strb[c*S1 +: S1]  = fs[c];
    s1.wdata[c*D1 +: D1] = fd[c];
  endtask

  task automatic new_req(input int c);
    pend[c] = 1'b1;
    fa[c]   = $urandom;
    fw[c]   = 1'($urandom_range(0, 1));
    fs[c]   = 4'($urandom);
    fd[c]   = $urandom;
    drive1(c);
  endtask

  task automatic test_reset();
    rstn0 = 1'b0; rstn1 = 1'b0;
    nxt(); nxt(); #1;
    checks++; if (m0.req !== 1'b0) begin errors++; $display("FAIL reset m_req0: got %0h want 0", m0.req); end
    checks++; if (m0.addr !== '0) begin errors++; $display("FAIL reset m_addr0: got %0h want 0", m0.addr); end
    checks++; if ({busy0, own0, tmo0, s0.gnt} !== 5'b0) begin errors++; $display("FAIL reset status0: got %0h want 0", {busy0, own0, tmo0, s0.gnt}); end
    checks++; if ({m1.req, m1.wen, m1.strb, m1.wdata} !== '0) begin errors++; $display("FAIL reset m_fields1: got %0h want 0", {m1.req, m1.wen, m1.strb, m1.wdata}); end
    checks++; if ({busy1, own1, tmo1, s1.gnt} !== 8'b0) begin errors++; $display("FAIL reset status1: got %0h want 0", {busy1, own1, tmo1, s1.gnt}); end
    rstn0 = 1'b1; rstn1 = 1'b1;
  endtask

  task automatic test_single();
    s0.req = 2'b01; s0.wen = 2'b00;
    s0.addr[0 +: A0] = 64'h1000; s0.addr[A0 +: A0] = 64'h2000;
    #1;
    checks++; if ({busy0, m0.req, s0.gnt} !== 4'b0) begin errors++; $display("FAIL single idle: got %0h want 0", {busy0, m0.req, s0.gnt}); end
    nxt();
    m0.gnt = 1'b1; m0.err = 1'b0; m0.rdata = 64'hDEAD; #1;
    checks++; if ({m0.req, m0.wen} !== 2'b10) begin errors++; $display("FAIL single m_req/wen: got %0h want 2", {m0.req, m0.wen}); end
    checks++; if (m0.addr !== 64'h1000) begin errors++; $display("FAIL single m_addr: got %0h want 1000", m0.addr); end
    checks++; if (s0.gnt !== 2'b01) begin errors++; $display("FAIL single s_gnt: got %0h want 1", s0.gnt); end
    checks++; if ({s0.err, s0.rdata} !== {1'b0, 64'hDEAD}) begin errors++; $display("FAIL single rdata/err: got %0h want dead", {s0.err, s0.rdata}); end
    nxt();
    s0.req = 2'b00; m0.gnt = 1'b0; #1;
    checks++; if ({busy0, s0.gnt, s0.rdata} !== '0) begin errors++; $display("FAIL single back idle: got %0h want 0", {busy0, s0.gnt, s0.rdata}); end
    nxt();
  endtask

  task automatic test_alternate();
    int exp_ch = 1;
    s0.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      m0.gnt = 1'b0; #1;
      checks++; if ({busy0, s0.gnt} !== 3'b0) begin errors++; $display("FAIL alt idle %0d: got %0h want 0", i, {busy0, s0.gnt}); end
      nxt();
      m0.gnt = 1'b1; m0.rdata = {$urandom, $urandom}; #1;
      checks++; if ({s0.gnt, own0} !== {2'(2'b01 << exp_ch), 1'(exp_ch)}) begin errors++; $display("FAIL alt grant %0d: got %0h want %0h", i, {s0.gnt, own0}, {2'(2'b01 << exp_ch), 1'(exp_ch)}); end
      checks++; if (m0.addr !== ((exp_ch == 1) ? 64'h2000 : 64'h1000)) begin errors++; $display("FAIL alt addr %0d: got %0h", i, m0.addr); end
      exp_ch = (exp_ch + 1) % 2;
      nxt();
    end
    s0.req = 2'b00; m0.gnt = 1'b0; #1;
    nxt();
  endtask

  task automatic test_no_timeout();
    s0.req = 2'b01; #1;
    nxt();
    for (int i = 0; i < 20; i++) begin
      m0.gnt = 1'b0; #1;
      checks++; if ({s0.gnt, tmo0, busy0} !== 4'b0001) begin errors++; $display("FAIL notimeout wait %0d: got %0h want 1", i, {s0.gnt, tmo0, busy0}); end
      nxt();
    end
    m0.gnt = 1'b1; #1;
    checks++; if (s0.gnt !== 2'b01) begin errors++; $display("FAIL notimeout gnt: got %0h want 1", s0.gnt); end
    nxt();
    s0.req = 2'b00; m0.gnt = 1'b0; #1;
    nxt();
  endtask

  task automatic test_reset_mid();
    s0.req = 2'b01; #1;
    nxt();
    rstn0 = 1'b0; s0.req = 2'b11; m0.gnt = 1'b0; #1;
    checks++; if ({busy0, own0} !== 2'b10) begin errors++; $display("FAIL rstmid busy: got %0h want 2", {busy0, own0}); end
    nxt();
    rstn0 = 1'b1; #1;
    checks++; if ({m0.req, busy0, s0.gnt, own0} !== 5'b0) begin errors++; $display("FAIL rstmid after: got %0h want 0", {m0.req, busy0, s0.gnt, own0}); end
    nxt();
    m0.gnt = 1'b1; #1;
    checks++; if ({s0.gnt, own0} !== 3'b010) begin errors++; $display("FAIL rstmid ptr0: got %0h want 2", {s0.gnt, own0}); end
    nxt();
    s0.req = 2'b00; m0.gnt = 1'b0; #1;
    nxt();
  endtask

  task automatic test_write_order();
    for (int c = 0; c < 4; c++) begin
      fa[c] = 32'(32'h100 * (c + 1)); fw[c] = (c == 2); fs[c] = (c == 2) ? 4'hF : 4'h0;
      fd[c] = (c == 2) ? 32'h1234 : 32'h0;
      drive1(c);
    end
    for (int i = 0; i < 4; i++) begin
      m1.gnt = 1'b0; #1;
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL order idle %0d: got %0h want 0", i, busy1); end
      nxt();
      m1.gnt = 1'b1; m1.err = 1'b0; #1;
      checks++; if ({own1, s1.gnt} !== {2'(i), 4'(4'b0001 << i)}) begin errors++; $display("FAIL order grant %0d: got %0h want %0h", i, {own1, s1.gnt}, {2'(i), 4'(4'b0001 << i)}); end
      checks++; if (m1.addr !== 32'(32'h100 * (i + 1))) begin errors++; $display("FAIL order addr %0d: got %0h", i, m1.addr); end
      if (i == 2) begin
        checks++; if ({m1.wen, m1.strb, m1.wdata} !== {1'b1, 4'hF, 32'h1234}) begin errors++; $display("FAIL order write: got %0h want 1f00001234", {m1.wen, m1.strb, m1.wdata}); end
      end
      nxt();
      s1.req[i] = 1'b0;
    end
    m1.gnt = 1'b0; #1;
    nxt();
  endtask

  task automatic test_timeout();
    fa[1] = 32'hABC0; fw[1] = 1'b0; fs[1] = 4'h0; fd[1] = 32'h0; drive1(1); #1;
    nxt();
    for (int k = 0; k < 4; k++) begin
      m1.gnt = 1'b0; m1.err = 1'b0; m1.rdata = 32'h5555AAAA; #1;
      if (k < 3) begin
        checks++; if ({s1.gnt, tmo1, busy1} !== 6'b000001) begin errors++; $display("FAIL tmo wait %0d: got %0h want 1", k, {s1.gnt, tmo1, busy1}); end
      end else begin
        checks++; if ({s1.gnt, s1.err, s1.rdata, tmo1} !== {4'b0010, 1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL tmo fire: got %0h want %0h", {s1.gnt, s1.err, s1.rdata, tmo1}, {4'b0010, 1'b1, 32'h0, 1'b1}); end
      end
      nxt();
    end
    s1.req[1] = 1'b0;
    fa[3] = 32'h3000; fw[3] = 1'b0; fs[3] = 4'h0; fd[3] = 32'h0; drive1(3);
    for (int j = 0; j < 3; j++) begin
      m1.gnt = (j == 2); #1;
      checks++; if ({m1.req, m1.addr, s1.gnt, tmo1} !== {1'b1, 32'hABC0, 4'b0, 1'b0}) begin errors++; $display("FAIL tmo drain %0d: got %0h", j, {m1.req, m1.addr, s1.gnt, tmo1}); end
      nxt();
    end
    m1.gnt = 1'b0; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL tmo post idle: got %0h want 0", busy1); end
    nxt();
    m1.gnt = 1'b1; m1.err = 1'b1; #1;
    checks++; if ({own1, s1.gnt, s1.err, tmo1} !== {2'd3, 4'b1000, 1'b1, 1'b0}) begin errors++; $display("FAIL merr grant: got %0h want %0h", {own1, s1.gnt, s1.err, tmo1}, {2'd3, 4'b1000, 1'b1, 1'b0}); end
    nxt();
    s1.req = '0; m1.gnt = 1'b0; m1.err = 1'b0; #1;
    nxt();
  endtask

  task automatic test_coincide();
    fa[0] = 32'h0C0C; fw[0] = 1'b0; fs[0] = 4'h0; fd[0] = 32'h0; drive1(0); #1;
    nxt();
    for (int k = 0; k < 4; k++) begin
      m1.gnt = (k == 3); m1.err = 1'b0; m1.rdata = 32'h600D; #1;
      if (k < 3) begin
        checks++; if ({s1.gnt, tmo1} !== 5'b0) begin errors++; $display("FAIL coincide wait %0d: got %0h want 0", k, {s1.gnt, tmo1}); end
      end else begin
        checks++; if ({s1.gnt, s1.err, s1.rdata, tmo1} !== {4'b0001, 1'b0, 32'h600D, 1'b0}) begin errors++; $display("FAIL coincide grant: got %0h", {s1.gnt, s1.err, s1.rdata, tmo1}); end
      end
      nxt();
    end
    s1.req = '0; m1.gnt = 1'b0; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL coincide no drain: got %0h want 0", busy1); end
    nxt();
  endtask

  task automatic test_random();
    int ptr, win, d;
    logic timed, er;
    logic [3:0] oh;
    logic [D1-1:0] rd;
    logic [A1+1+S1+D1-1:0] cap;
    for (int c = 0; c < 4; c++) pend[c] = 1'b0;
    rstn1 = 1'b0; s1.req = '0; m1.gnt = 1'b0; m1.err = 1'b0;
    nxt();
    rstn1 = 1'b1;
    ptr = 0;
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 4; c++) if (!pend[c] && $urandom_range(0, 1) == 1) new_req(c);
      if (!(pend[0] | pend[1] | pend[2] | pend[3])) new_req(int'($urandom_range(0, 3)));
      win = -1;
      for (int k = 0; k < 4; k++) if (win < 0 && pend[(ptr + k) % 4]) win = (ptr + k) % 4;
      oh  = 4'(4'b0001 << win);
      cap = {fa[win], fw[win], fs[win], fd[win]};
      m1.gnt = 1'b0; #1;
      checks++; if ({busy1, s1.gnt, s1.err, s1.rdata, tmo1} !== '0) begin errors++; $display("FAIL rand idle t%0d: got %0h want 0", t, {busy1, s1.gnt, s1.err, s1.rdata, tmo1}); end
      nxt();
      d = int'($urandom_range(0, 6));
      timed = 1'b0;
      for (int k = 0; k <= d; k++) begin
        for (int c = 0; c < 4; c++) if (!pend[c] && $urandom_range(0, 3) == 0) new_req(c);
        if (!timed) s1.addr[win*A1 +: A1] = $urandom;
        rd = $urandom; er = 1'($urandom_range(0, 1));
        m1.gnt = (k == d); m1.err = er; m1.rdata = rd;
        #1;
        checks++; if ({m1.req, own1, m1.addr, m1.wen, m1.strb, m1.wdata} !== {1'b1, 2'(win), cap}) begin errors++; $display("FAIL rand fields t%0d k%0d: got %0h want %0h", t, k, {m1.req, own1, m1.addr, m1.wen, m1.strb, m1.wdata}, {1'b1, 2'(win), cap}); end
        if (timed || (k != d && k != 3)) begin
          checks++; if ({s1.gnt, tmo1} !== 5'b0) begin errors++; $display("FAIL rand quiet t%0d k%0d: got %0h want 0", t, k, {s1.gnt, tmo1}); end
        end else if (k == d) begin
          checks++; if ({s1.gnt, s1.err, s1.rdata, tmo1} !== {oh, er, rd, 1'b0}) begin errors++; $display("FAIL rand resp t%0d: got %0h want %0h", t, {s1.gnt, s1.err, s1.rdata, tmo1}, {oh, er, rd, 1'b0}); end
          pend[win] = 1'b0; s1.req[win] = 1'b0;
        end else begin
          checks++; if ({s1.gnt, s1.err, s1.rdata, tmo1} !== {oh, 1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL rand timeout t%0d: got %0h want %0h", t, {s1.gnt, s1.err, s1.rdata, tmo1}, {oh, 1'b1, 32'h0, 1'b1}); end
          timed = 1'b1; pend[win] = 1'b0; s1.req[win] = 1'b0;
        end
        nxt();
      end
      ptr = (win + 1) % 4;
    end
    s1.req = '0; m1.gnt = 1'b0;
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    s0.req = '0; s0.addr = '0; s0.wen = '0; s0.strb = '0; s0.wdata = '0;
    s1.req = '0; s1.addr = '0; s1.wen = '0; s1.strb = '0; s1.wdata = '0;
    m0.gnt = '0; m0.err = 1'b0; m0.rdata = '0;
    m1.gnt = '0; m1.err = 1'b0; m1.rdata = '0;
    test_reset();
    test_single();
    test_alternate();
    test_no_timeout();
    test_reset_mid();
    test_write_order();
    test_timeout();
    test_coincide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Parametrised N-to-1 arbiter for the core memory request/response protocol.
- Merges CHANNELS requestor ports (e.g. fetch, load/store, debug) onto one responder port.
- Round-robin fairness; one outstanding transaction at a time.
- Registered downstream request; optional response timeout returns an error to the requestor and drains the late response.

Parameters:
CHANNELS, 2, number of requestor channels (>=2)
MEM_ADDR_W, 64, address width
MEM_STRB_W, 8, write strobe width
MEM_DATA_W, 64, data width
TIMEOUT, 255, BUSY cycles without m_gnt before error; 0 disables timeout
OWNER_W, max(1,$clog2(CHANNELS)), derived localparam, owner index width

Ports:
g_clk  in  1  clock, all logic on rising edge
g_resetn  in  1  synchronous active-low reset
s_req  in  CHANNELS  per-channel request
s_addr  in  CHANNELS*MEM_ADDR_W  channel i at [i*MEM_ADDR_W +: MEM_ADDR_W]
s_wen  in  CHANNELS  per-channel write enable
s_strb  in  CHANNELS*MEM_STRB_W  packed as s_addr
s_wdata  in  CHANNELS*MEM_DATA_W  packed as s_addr
s_gnt  out  CHANNELS  one-hot response valid to owner
s_err  out  1  response error, qualified by s_gnt
s_rdata  out  MEM_DATA_W  read data, qualified by s_gnt
m_req  out  1  downstream request
m_addr  out  MEM_ADDR_W  downstream address
m_wen  out  1  downstream write enable
m_strb  out  MEM_STRB_W  downstream strobe
m_wdata  out  MEM_DATA_W  downstream write data
m_gnt  in  1  downstream response valid
m_err  in  1  downstream response error
m_rdata  in  MEM_DATA_W  downstream read data
busy  out  1  FSM not IDLE
owner  out  OWNER_W  current/last granted channel
timeout  out  1  one-cycle pulse on timeout

Behaviour:
- Protocol: a requestor holds req and its fields stable until its gnt. gnt is a single-cycle pulse that completes the transaction, with rdata/err valid in the same cycle.
- Reset (g_resetn=0 at an edge):
  - state=IDLE, ptr=0, owner=0, counter=0.
  - m_req=0; m_addr/m_wen/m_strb/m_wdata=0.
  - s_gnt=0, timeout=0, busy=0.
  - Reset mid-transaction abandons it; no s_gnt is issued.
- IDLE, one or more s_req set:
  - Winner = first set s_req scanning ptr, ptr+1, ... modulo CHANNELS.
  - Register owner=winner and capture its addr/wen/strb/wdata into m_* registers.
  - Next state BUSY; counter=0.
  - No s_gnt is issued in IDLE.
- BUSY:
  - m_req=1 with the captured fields. Later changes on s_* inputs are ignored.
  - s_gnt[owner]=m_gnt; s_err=m_err; s_rdata=m_rdata (combinational).
  - On m_gnt: next state IDLE, m_req deasserts, ptr=(owner+1) mod CHANNELS.
  - Minimum latency: s_req at cycle 0 gives s_gnt at cycle 1 if m_gnt responds immediately.
  - Otherwise counter increments each cycle.
  - If TIMEOUT!=0, counter==TIMEOUT-1 and m_gnt=0: assert s_gnt[owner]=1, s_err=1, s_rdata=0 and timeout=1 for that cycle. Next state DRAIN.
  - If m_gnt and the timeout condition coincide, m_gnt wins and no timeout fires.
- DRAIN:
  - m_req stays 1 with the same fields; s_gnt=0.
  - m_gnt is absorbed and discarded.
  - On m_gnt: next state IDLE, ptr=(owner+1) mod CHANNELS.
  - New requests wait.
- When not BUSY: s_gnt=0, s_err=0, s_rdata=0.
- A channel that keeps req high after its gnt is treated as a new request; round-robin order applies.
- owner holds its value in IDLE.
- Fairness: each requesting channel is served within CHANNELS transactions.

Test Plan:
- Reset, then s_req=01 with addr0=0x1000, wen=0; m_gnt at the first BUSY cycle with rdata=0xDEAD -> m_addr=0x1000 one cycle after req; s_gnt=01, s_rdata=0xDEAD; busy back to 0.
- s_req=11 held continuously, m_gnt immediate -> grants alternate ch0, ch1, ch0, ch1; owner toggles; each grant occupies 2 cycles.
- CHANNELS=4, all requesting, ch2 write strb=0x0F wdata=0x1234 -> grant order 0,1,2,3; ch2 transaction shows m_wen=1, m_strb=0x0F, m_wdata=0x1234.
- TIMEOUT=4, m_gnt withheld -> s_gnt[owner]=1 with s_err=1 on the 4th BUSY cycle and timeout pulses. Late m_gnt 3 cycles later is absorbed (s_gnt stays 0); the next arbitration starts the cycle after.
- m_gnt with m_err=1 -> s_gnt[owner]=1, s_err=1, timeout=0. Same with m_gnt coinciding with counter==TIMEOUT-1 -> normal completion, timeout=0.
- g_resetn low for 1 cycle during BUSY -> m_req=0 and busy=0 next cycle, no s_gnt; a pending ch1 request is arbitrated from ptr=0.
